// File: rtl/wb_load_seq.sv
// wb_load_seq: master of the weight/input reader handshake.
// After a start, sweeps every network input (phase 0), then every weight and
// bias of every layer (phase 1). Each value is requested with a one-cycle rs
// pulse. The sequencer waits for rf and then writes the value into the input
// or weight buffer at a linear address.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a load (honoured in IDLE only)
//   layers, nlayers       per-layer neuron counts (8 bits each), valid layer count
//   rlayer, rn, rin       index of the value requested from the reader
//   rmode, rs             0 = input / 1 = weight or bias; one-cycle request pulse
//   ram_in, ram_w, rf     reader data and sticky finished flag
//   in_we/in_addr/in_data input buffer write port
//   w_we/w_addr/w_data    weight buffer write port
//   busy, done, err       run status; err is sticky until the next start
//   wcount                weights written in the current or last run
module wb_load_seq #(
  parameter int maxl   = 5,
  parameter int sizein = 32,
  parameter int sizew  = 8,
  parameter int WA     = 16,
  parameter int TMO    = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [maxl*8-1:0]   layers,
  input  logic [7:0]          nlayers,
  output logic [7:0]          rlayer,
  output logic [7:0]          rn,
  output logic [7:0]          rin,
  output logic                rmode,
  output logic                rs,
  input  logic [sizein-1:0]   ram_in,
  input  logic [sizew-1:0]    ram_w,
  input  logic                rf,
  output logic                in_we,
  output logic [WA-1:0]       in_addr,
  output logic [sizein-1:0]   in_data,
  output logic                w_we,
  output logic [WA-1:0]       w_addr,
  output logic [sizew-1:0]    w_data,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [WA-1:0]       wcount
);

  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT_RF, S_WRITE, S_NEXT, S_FIN
  } state_t;

  state_t              state, state_nx;
  logic [maxl*8-1:0]   lay_q;     // layer sizes captured at start
  logic [7:0]          nl_q;
  logic                phase;     // 0 = network inputs, 1 = weights/biases
  logic [7:0]          l_cnt, n_cnt, i_cnt;
  logic [TW-1:0]       tmo_cnt;
  logic [WA-1:0]       wcnt;
  logic                err_q;

  logic                cfg_bad, i_last, n_last, l_last, tmo_hit;
  logic [7:0]          l_cur, l_prev;

  // Neuron count of layer k; 0 for any index outside the table.
  function automatic logic [7:0] lsize(input logic [maxl*8-1:0] lay, input logic [7:0] k);
    lsize = '0;
    for (int j = 0; j < maxl; j++)
      if (k == 8'(j)) lsize = lay[8*j +: 8];
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    cfg_bad = (nl_q < 8'd2) || (nl_q > 8'(maxl));
    for (int j = 0; j < maxl; j++)
      if ((8'(j) < nl_q) && (lay_q[8*j +: 8] == 8'd0)) cfg_bad = 1'b1;
    l_cur   = lsize(lay_q, l_cnt);
    l_prev  = lsize(lay_q, l_cnt - 8'd1);
    // Phase 1 runs i one past the fan-in; that extra index is the bias.
    i_last  = phase ? (i_cnt == l_prev) : (i_cnt == l_cur - 8'd1);
    n_last  = (n_cnt == l_cur - 8'd1);
    l_last  = (l_cnt == nl_q - 8'd1);
    tmo_hit = (tmo_cnt == TW'(TMO - 1));

    state_nx = state;
    unique case (state)
      S_IDLE:    if (start) state_nx = S_CHECK;
      S_CHECK:   state_nx = cfg_bad ? S_FIN : S_ISSUE;
      S_ISSUE:   state_nx = S_WAIT_RF;
      S_WAIT_RF: if (rf) state_nx = S_WRITE;
                 else if (tmo_hit) state_nx = S_FIN;
      S_WRITE:   state_nx = S_NEXT;
      S_NEXT:    state_nx = (phase && i_last && n_last && l_last) ? S_FIN : S_ISSUE;
      S_FIN:     state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lay_q   <= '0;
      nl_q    <= '0;
      phase   <= 1'b0;
      l_cnt   <= '0;
      n_cnt   <= '0;
      i_cnt   <= '0;
      tmo_cnt <= '0;
      wcnt    <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      unique case (state)
        S_IDLE: if (start) begin
          lay_q <= layers;
          nl_q  <= nlayers;
          err_q <= 1'b0;
          wcnt  <= '0;
          phase <= 1'b0;
          l_cnt <= '0;
          n_cnt <= '0;
          i_cnt <= '0;
        end
        S_CHECK:   if (cfg_bad) err_q <= 1'b1;
        S_ISSUE:   tmo_cnt <= '0;
        S_WAIT_RF: if (!rf) begin
          if (tmo_hit) err_q <= 1'b1;
          else         tmo_cnt <= tmo_cnt + 1'b1;
        end
        S_WRITE:   if (phase) wcnt <= wcnt + 1'b1;
        S_NEXT: begin
          if (!phase) begin
            if (i_last) begin
              phase <= 1'b1;
              l_cnt <= 8'd1;
              n_cnt <= '0;
              i_cnt <= '0;
            end else begin
              i_cnt <= i_cnt + 8'd1;
            end
          end else if (i_last) begin
            i_cnt <= '0;
            if (!n_last) begin
              n_cnt <= n_cnt + 8'd1;
            end else if (!l_last) begin
              n_cnt <= '0;
              l_cnt <= l_cnt + 8'd1;
            end
          end else begin
            i_cnt <= i_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Index outputs come straight from the counters, which only move in NEXT,
  // so they stay stable from ISSUE through WRITE.
  assign rlayer  = l_cnt;
  assign rn      = n_cnt;
  assign rin     = i_cnt;
  assign rmode   = phase;
  assign rs      = (state == S_ISSUE);
  assign in_we   = (state == S_WRITE) && !phase;
  assign w_we    = (state == S_WRITE) && phase;
  assign in_addr = in_we ? WA'(i_cnt) : '0;
  assign in_data = in_we ? ram_in : '0;
  assign w_addr  = w_we ? wcnt : '0;
  assign w_data  = w_we ? ram_w : '0;
  assign busy    = (state != S_IDLE) && (state != S_FIN);
  assign done    = (state == S_FIN);
  assign err     = err_q;
  assign wcount  = wcnt;

endmodule

// File: tb/tb_wb_load_seq.sv
// Self-checking bench for wb_load_seq: a reader model with random latency and
// sticky rf, a list-based model of the expected request/write sequence, and a
// compare process that checks every request and every buffer write.
module tb_wb_load_seq;
  localparam int MAXL = 5;
  localparam int SIZEIN = 32;
  localparam int SIZEW = 8;
  localparam int WA = 16;
  localparam int TMO = 16;
  localparam int LW = MAXL * 8;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [LW-1:0] layers = '0;
  logic [7:0] nlayers = '0;
  logic [7:0] rlayer, rn, rin;
  logic rmode, rs, in_we, w_we, busy, done, err;
  logic [SIZEIN-1:0] ram_in = '0, in_data;
  logic [SIZEW-1:0] ram_w = '0, w_data;
  logic rf = 1'b0;
  logic [WA-1:0] in_addr, w_addr, wcount;

  wb_load_seq #(.maxl(MAXL), .sizein(SIZEIN), .sizew(SIZEW), .WA(WA), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .layers(layers), .nlayers(nlayers),
    .rlayer(rlayer), .rn(rn), .rin(rin), .rmode(rmode), .rs(rs),
    .ram_in(ram_in), .ram_w(ram_w), .rf(rf),
    .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .busy(busy), .done(done), .err(err), .wcount(wcount));

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // ---------------- reader model ----------------
  logic [15:0] salt = '0;
  int stall_at = 0, max_lat = 0;
  bit rd_clr = 1'b0;
  int rd_n = 0, rd_lat = 0;
  bit rd_pend = 1'b0;
  logic [7:0] cap_l = '0, cap_n = '0, cap_i = '0;
  logic cap_m = 1'b0;

  function automatic logic [SIZEIN-1:0] in_val(input logic [7:0] i);
    return {salt, 8'h5a, i};
  endfunction
  function automatic logic [SIZEW-1:0] w_val(input logic [7:0] l, input logic [7:0] n,
                                             input logic [7:0] i);
    return i ^ {n[4:0], 3'b000} ^ {l[1:0], 6'd0} ^ salt[7:0];
  endfunction

  // rf stays high between reads and is cleared on the edge that takes rs.
  always @(posedge clk) begin
    if (rd_clr) rd_n <= 0;
    else if (rs) rd_n <= rd_n + 1;
    if (rs) begin
      rf <= 1'b0;
      cap_m <= rmode; cap_l <= rlayer; cap_n <= rn; cap_i <= rin;
      rd_lat <= int'($urandom_range(max_lat, 0));
      rd_pend <= !(stall_at != 0 && rd_n + 1 >= stall_at);
    end else if (rd_pend) begin
      if (rd_lat == 0) begin
        rf <= 1'b1;
        ram_in <= cap_m ? SIZEIN'($urandom) : in_val(cap_i);
        ram_w <= cap_m ? w_val(cap_l, cap_n, cap_i) : SIZEW'($urandom);
        rd_pend <= 1'b0;
      end else begin
        rd_lat <= rd_lat - 1;
      end
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct packed { logic m; logic [7:0] l; logic [7:0] n; logic [7:0] i; } req_t;
  typedef struct packed { logic w; logic [WA-1:0] a; logic [SIZEIN-1:0] d; } wr_t;
  req_t exp_req[$];
  wr_t exp_wr[$];
  logic [7:0] cfg[MAXL];
  int exp_nrs = 0, exp_nwr = 0, exp_wc = 0, gen = 0, run_d0 = 0;
  bit exp_err = 1'b0;

  task automatic build(input int nl, input int stall);
    bit bad;
    int k, total;
    exp_req.delete();
    exp_wr.delete();
    bad = (nl < 2) || (nl > MAXL);
    for (int j = 0; j < MAXL; j++) if (j < nl && cfg[j] == 8'd0) bad = 1'b1;
    if (!bad) begin
      for (int i = 0; i < cfg[0]; i++) begin
        exp_req.push_back(req_t'{1'b0, 8'd0, 8'd0, 8'(i)});
        exp_wr.push_back(wr_t'{1'b0, WA'(i), in_val(8'(i))});
      end
      k = 0;
      for (int l = 1; l < nl; l++)
        for (int n = 0; n < cfg[l]; n++)
          for (int i = 0; i <= cfg[l-1]; i++) begin
            exp_req.push_back(req_t'{1'b1, 8'(l), 8'(n), 8'(i)});
            exp_wr.push_back(wr_t'{1'b1, WA'(k), SIZEIN'(w_val(8'(l), 8'(n), 8'(i)))});
            k++;
          end
    end
    total = exp_req.size();
    if (stall > 0 && stall <= total) begin
      exp_nrs = stall; exp_nwr = stall - 1; exp_err = 1'b1;
    end else begin
      exp_nrs = total; exp_nwr = total; exp_err = bad;
    end
    exp_wc = 0;
    for (int j = 0; j < exp_nwr; j++) if (exp_wr[j].w) exp_wc++;
  endtask

  // ---------------- compare process ----------------
  int ri = 0, wi = 0, my_gen = 0, done_cnt = 0, done_cyc = 0, last_rs_cyc = 0;
  int n_in_wr = 0, n_w_wr = 0, first_wr_cyc = 0;
  req_t held = '0;
  wr_t cur_wr = '0;
  bit prev_rs = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_rs = 1'b0;
    end else begin
      if (gen != my_gen) begin
        my_gen = gen; ri = 0; wi = 0; n_in_wr = 0; n_w_wr = 0;
      end
      if (rs) begin
        check("rs single cycle", 64'(prev_rs), 64'(0));
        check("busy during rs", 64'(busy), 64'(1));
        if (ri < exp_req.size()) begin
          held = exp_req[ri];
          check("request index", 64'({rmode, rlayer, rn, rin}), 64'(held));
        end else begin
          check("extra rs", 64'(ri + 1), 64'(exp_req.size()));
        end
        ri++;
        last_rs_cyc = cyc;
      end
      prev_rs = rs;
      if (in_we || w_we) begin
        check("single strobe", 64'(in_we & w_we), 64'(0));
        check("one write per rs", 64'(wi < ri), 64'(1));
        check("index held to write", 64'({rmode, rlayer, rn, rin}), 64'(held));
        if (wi < exp_wr.size()) begin
          cur_wr = exp_wr[wi];
          if (cur_wr.w)
            check("weight write", 64'({w_we, w_addr, w_data}),
                  64'({1'b1, cur_wr.a, cur_wr.d[SIZEW-1:0]}));
          else
            check("input write", 64'({in_we, in_addr, in_data}), 64'({1'b1, cur_wr.a, cur_wr.d}));
        end else begin
          check("extra write", 64'(wi + 1), 64'(exp_wr.size()));
        end
        if (wi == 0) first_wr_cyc = cyc;
        wi++;
        if (w_we) n_w_wr++; else n_in_wr++;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  function automatic logic any_out();
    return |{rlayer, rn, rin, rmode, rs, in_we, in_addr, in_data, w_we, w_addr, w_data,
             busy, done, err, wcount};
  endfunction

  // ---------------- driver ----------------
  task automatic launch(input int nl, input int stall, input int lat);
    salt = 16'($urandom);
    stall_at = stall;
    max_lat = lat;
    build(nl, stall);
    rd_clr = 1'b1;
    @(negedge clk);
    rd_clr = 1'b0;
    for (int k = 0; k < MAXL; k++) layers[8*k +: 8] = cfg[k];
    nlayers = 8'(nl);
    gen++;
    start = 1'b1;
    run_d0 = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    // Inputs are scrambled after acceptance; the DUT must use its captured copy.
    layers = LW'({$urandom, $urandom});
    nlayers = 8'($urandom);
    check("busy after start", 64'(busy), 64'(1));
  endtask

  task automatic run(input int nl, input int stall, input int lat, input bit poke);
    int c, prev;
    prev = done_cnt;
    launch(nl, stall, lat);
    c = 0;
    while (done_cnt == prev && c < 20000) begin
      start = poke && (c == 12);
      if (start) nlayers = 8'd1;
      @(negedge clk); #1;
      c++;
    end
    start = 1'b0;
    check("done seen", 64'(done_cnt != prev), 64'(1));
    check("done with busy low", 64'({done, busy}), 64'(2'b10));
    check("err", 64'(err), 64'(exp_err));
    check("wcount", 64'(wcount), 64'(WA'(exp_wc)));
    check("rs count", 64'(ri), 64'(exp_nrs));
    check("write count", 64'(wi), 64'(exp_nwr));
    @(negedge clk); #1;
    check("done one cycle", 64'({done, busy, err}), 64'({2'b00, exp_err}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    for (int k = 0; k < MAXL; k++) cfg[k] = 8'd0;
    repeat (3) @(negedge clk);
    check("reset outputs zero", 64'(any_out()), 64'(0));
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("idle after reset", 64'(any_out()), 64'(0));

    // Two-layer net {3,2}, zero reader latency.
    cfg[0] = 8'd3; cfg[1] = 8'd2;
    run(2, 0, 0, 1'b0);
    check("2-layer wcount literal", 64'(wcount), 64'(8));
    check("2-layer input writes", 64'(n_in_wr), 64'(3));
    check("2-layer weight writes", 64'(n_w_wr), 64'(8));
    check("first write latency", 64'(first_wr_cyc - run_d0), 64'(5));

    // Three-layer net {4,3,2}, random latency, start poked while busy.
    cfg[0] = 8'd4; cfg[1] = 8'd3; cfg[2] = 8'd2;
    run(3, 0, 3, 1'b1);
    check("model weight total", 64'(exp_req.size() - 4), 64'(23));
    check("model bias l=1", 64'({exp_req[8].l, exp_req[8].i}), 64'({8'd1, 8'd4}));
    check("model bias l=2", 64'({exp_req[22].l, exp_req[22].i}), 64'({8'd2, 8'd3}));
    check("3-layer wcount literal", 64'(wcount), 64'(23));

    // Sticky rf with back-to-back reads.
    run(3, 0, 0, 1'b1);

    // Config errors: done two cycles after start, nothing issued.
    run(1, 0, 0, 1'b0);
    check("nlayers=1 done timing", 64'(done_cyc - run_d0), 64'(2));
    check("nlayers=1 no rs", 64'(ri), 64'(0));
    cfg[1] = 8'd0;
    run(2, 0, 0, 1'b0);
    check("L1=0 done timing", 64'(done_cyc - run_d0), 64'(2));
    check("L1=0 no writes", 64'(wi), 64'(0));

    // Timeout: reader stops answering after the 5th rs.
    cfg[0] = 8'd4; cfg[1] = 8'd3;
    run(2, 6, 2, 1'b0);
    check("timeout done timing", 64'(done_cyc - last_rs_cyc), 64'(TMO + 1));
    check("timeout wcount literal", 64'(wcount), 64'(1));

    // Asynchronous reset during the third weight read, then a clean rerun.
    cfg[0] = 8'd4; cfg[1] = 8'd3; cfg[2] = 8'd2;
    launch(3, 0, 1);
    c = 0;
    while (!(n_w_wr == 2 && ri == 7) && c < 2000) begin @(negedge clk); #1; c++; end
    check("reached weight 3", 64'(ri), 64'(7));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async reset clears outputs", 64'(any_out()), 64'(0));
    repeat (2) @(negedge clk);
    #1;
    check("outputs held in reset", 64'(any_out()), 64'(0));
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("idle after mid-run reset", 64'(any_out()), 64'(0));
    run(3, 0, 2, 1'b1);

    // Random networks.
    for (int r = 0; r < 8; r++) begin
      int nl;
      nl = int'($urandom_range(MAXL, 2));
      for (int k = 0; k < MAXL; k++) cfg[k] = 8'($urandom_range(4, 1));
      if (r == 5) cfg[$urandom_range(nl - 1, 0)] = 8'd0;
      run(nl, 0, int'($urandom_range(4, 0)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_load_seq.md
Name: wb_load_seq

Overview:
- Sequencer that drives the weight/input reader handshake (rlayer/rn/rin/rmode/rs in, ram_in/ram_w/rf out).
- Sweeps the whole network description: first all network inputs, then every weight and bias of every layer.
- Streams each fetched value into on-chip input and weight buffers at linear addresses.
- Sits between the network-load command logic and the reader; the only master of the reader's request ports.

Parameters:
maxl, 5, max layer count including the input layer; layers is packed 8 bits per layer, layer 0 in bits [7:0]
sizein, 32, input word width
sizew, 8, weight word width
WA, 16, width of w_addr, in_addr and wcount
TMO, 1024, cycles to wait for rf before a timeout error

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a load; sampled in IDLE only
layers  in  maxl*8  per-layer neuron counts
nlayers  in  8  number of valid layers including the input layer
rlayer  out  8  layer index to reader
rn  out  8  neuron index to reader
rin  out  8  input index to reader; index L[l-1] selects the bias
rmode  out  1  0 = input, 1 = weight/bias
rs  out  1  reader start pulse
ram_in  in  sizein  input value from reader
ram_w  in  sizew  weight value from reader
rf  in  1  reader finished; sticky until the reader accepts the next rs
in_we  out  1  input buffer write strobe
in_addr  out  WA  input buffer address
in_data  out  sizein  input buffer data
w_we  out  1  weight buffer write strobe
w_addr  out  WA  weight buffer address
w_data  out  sizew  weight buffer data
busy  out  1  high from start acceptance until done
done  out  1  one-cycle completion pulse
err  out  1  error flag; sticky until the next accepted start
wcount  out  WA  weights written in the current or last run

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0, including rs, in_we, w_we, busy, done, err, wcount, and all index outputs.
- Reset mid-run aborts immediately; no further writes occur. The reader is not reset by this block.
- L[k] = layers[8k+7:8k].
- States: IDLE, CHECK, ISSUE, WAIT_RF, WRITE, NEXT, FIN.
- IDLE:
  - On start: latch layers and nlayers into internal copies (inputs may change afterwards).
  - Set busy=1, clear err and wcount, go to CHECK.
  - start while busy is ignored.
- CHECK (1 cycle): error if nlayers<2, nlayers>maxl, or L[k]==0 for any k<nlayers.
  - On error: err=1, go to FIN. No rs is issued.
  - Otherwise enter phase 0 with (l=0, n=0, i=0).
- Phase 0 (inputs): rmode=0, rin=i for i=0..L[0]-1, rlayer=0, rn=0.
- Phase 1 (weights): rmode=1. Loop order, outermost to innermost:
  - l = 1..nlayers-1
  - n = 0..L[l]-1
  - i = 0..L[l-1]; the last i is the bias
- ISSUE:
  - Drive the index outputs and rmode; rs=1 for exactly one cycle; go to WAIT_RF.
  - Index outputs and rmode are held stable from ISSUE until leaving WRITE.
- WAIT_RF:
  - Starts the cycle after rs falls, so a stale rf from the previous read is never sampled (the reader clears rf on the edge it takes rs).
  - On rf=1, go to WRITE.
  - A timeout counter starts at 0 on entry. When it reaches TMO-1 without rf: err=1, go to FIN.
- WRITE (1 cycle):
  - Phase 0: in_we=1, in_addr=i, in_data=ram_in.
  - Phase 1: w_we=1, w_addr=wcount, w_data=ram_w, then wcount+1.
  - Strobes are high for exactly one cycle per fetched value.
- NEXT:
  - Advance i, then n, then l.
  - Phase 0 finishing moves to phase 1 with l=1.
  - Phase 1 finishing goes to FIN; otherwise go to ISSUE.
- Counter width: index counters are 8 bits, with L values at most 255.
  - i reaches L[l-1] at most, which still fits in 8 bits.
  - wcount wraps at 2^WA; no error is raised. Total weights = sum over l of L[l]*(L[l-1]+1).
- FIN: done=1 for one cycle, busy=0, go to IDLE. err holds.
- Per-value latency: 1 (ISSUE) + reader latency + 1 (WRITE) + 1 (NEXT).

Test Plan:
- Two-layer net, nlayers=2, L0=3, L1=2; reader model returns data = address low byte.
  - Expect 3 input writes at in_addr 0..2, then 8 weight writes at w_addr 0..7.
  - Index sequence (1,0,0..3),(1,1,0..3); wcount=8; one done pulse; err=0.
- Three-layer net, L={4,3,2}:
  - Expect 3*5 + 2*4 = 23 weight writes in (l,n,i) order.
  - Bias reads at rin=4 for l=1 and rin=3 for l=2.
- Stale rf: reader model holds rf=1 between reads and clears it on the edge it takes rs.
  - Expect exactly one write per rs, with no double write.
- Config errors: nlayers=1, then nlayers=2 with L1=0.
  - Each run: err=1, done after 2 cycles, zero rs pulses, no writes.
- Timeout: reader never asserts rf after the 5th rs, with TMO=16.
  - err=1 and done 16 cycles into WAIT_RF; wcount=1 (4 inputs with L0=4, then 1 weight).
- Reset and restart:
  - rst_n low during weight 3: all outputs 0 asynchronously.
  - A new start after release reruns from in_addr 0.
  - start pulsed while busy is ignored.
